nv_nvdla_nocif_axi_rsp: RTL and testbench
=========================================

Name: nv_nvdla_nocif_axi_rsp

Overview:
- AXI responder (DRAM-side slave model) for the NOCIF DRAM master port: accepts AR/AW/W, returns R/B.
- Backed by an internal flop-array memory; incrementing bursts; one outstanding read and one outstanding write, with independent read and write engines.
- Used as a synthesizable memory stand-in for block-level bring-up and emulation of the NOCIF/MCIF path.

Parameters:
- ADDR_W, 64, width of araddr/awaddr.
- DATA_W, 64, width of rdata/wdata; power of two, >=8.
- DEPTH_LOG2, 8, log2 of memory words (DATA_W bits each).

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- mcif2noc_axi_ar_arvalid  in  1  read address valid
- mcif2noc_axi_ar_arready  out  1  read address ready
- mcif2noc_axi_ar_arid  in  8  read id
- mcif2noc_axi_ar_arlen  in  4  beats-1
- mcif2noc_axi_ar_araddr  in  ADDR_W  byte address
- noc2mcif_axi_r_rvalid  out  1  read data valid
- noc2mcif_axi_r_rready  in  1  read data ready
- noc2mcif_axi_r_rid  out  8  read id echo
- noc2mcif_axi_r_rlast  out  1  last beat
- noc2mcif_axi_r_rdata  out  DATA_W  read data
- mcif2noc_axi_aw_awvalid  in  1  write address valid
- mcif2noc_axi_aw_awready  out  1  write address ready
- mcif2noc_axi_aw_awid  in  8  write id
- mcif2noc_axi_aw_awlen  in  4  beats-1
- mcif2noc_axi_aw_awaddr  in  ADDR_W  byte address
- mcif2noc_axi_w_wvalid  in  1  write data valid
- mcif2noc_axi_w_wready  out  1  write data ready
- mcif2noc_axi_w_wdata  in  DATA_W  write data
- mcif2noc_axi_w_wstrb  in  DATA_W/8  byte enables
- mcif2noc_axi_w_wlast  in  1  last write beat
- noc2mcif_axi_b_bvalid  out  1  write response valid
- noc2mcif_axi_b_bready  in  1  write response ready
- noc2mcif_axi_b_bid  out  8  write id echo
- proto_err  out  1  sticky: wlast/awlen mismatch seen

Behaviour:
- Word index = addr[log2(DATA_W/8) +: DEPTH_LOG2]; low byte-offset bits ignored; upper bits ignored (aliasing). Index increments by 1 per beat, wrapping modulo 2^DEPTH_LOG2.
- Reset: all FSMs to IDLE. arready=1, awready=1; rvalid=0, wready=0, bvalid=0, proto_err=0; rid/bid/rdata/rlast=0. Memory contents not reset (undefined; bench initialises by writes).
- Read FSM R_IDLE/R_BURST:
  - R_IDLE: arready=1. On arvalid&arready, latch id, len, index; load rdata register with mem[index]; go to R_BURST. Data is valid 1 cycle after AR handshake.
  - R_BURST: arready=0, rvalid=1, rid=latched id, rlast=(beat==len). On rvalid&rready: beat++, index++, rdata reloads from mem[index+1]. If last, go to R_IDLE.
  - rdata/rid/rlast hold stable while rvalid&!rready.
  - Back-to-back bursts have 1 idle cycle on AR.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: awready=1, wready=0. On AW handshake, latch id, len, index; go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write bytes with wstrb[b]=1 into mem[index]; beat++, index++.
  - Terminate when beat==len. If wlast!=(beat==len), set proto_err (sticky until reset); the burst still ends at beat==len.
  - W_RESP: bvalid=1, bid=latched id. On bready, go to W_IDLE.
  - W beats arriving before AW are held off (wready=0).
- Read/write collision on the same word in the same cycle: the rdata register captures the pre-write content. A write is visible to any read load in a later cycle.
- wstrb=0 beat: handshake completes, memory unchanged.
- Reset mid-burst: FSMs abort to IDLE, in-flight beats dropped, no B/R issued; memory retains contents.

Test Plan:
- AW id=0x12 len=3 addr=0x100, 4 W beats 0xA0..0xA3 strb=0xFF, wlast on beat 3 -> one B with bid=0x12 after last beat; proto_err=0.
- Then AR id=0x34 len=3 addr=0x100, rready=1 -> rvalid 1 cycle after AR, 4 beats 0xA0..0xA3, rid=0x34, rlast on 4th only.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with strb=0x0F to the same address, read back -> 0xFFFF_FFFF_0000_0000.
- Wrap: DEPTH_LOG2=8, AW addr=0x7F8 len=1 -> words 255 and 0 written; reading addr 0x0 returns the second beat.
- R backpressure: rready toggling 1/0 every cycle during len=7 burst -> data stable while stalled; 8 beats in order; arready=0 throughout.
- wlast asserted on beat 1 of a len=2 burst -> proto_err=1 stays set; B issued after beat 2; assert reset -> proto_err=0, bvalid=0.

Source files
------------

// File: rtl/nv_nvdla_nocif_axi_rsp_if.sv
// AXI bus bundle between the NOCIF DRAM master port and the responder model.
interface nv_nvdla_nocif_axi_rsp_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                mcif2noc_axi_ar_arvalid;
  logic                mcif2noc_axi_ar_arready;
  logic [7:0]          mcif2noc_axi_ar_arid;
  logic [3:0]          mcif2noc_axi_ar_arlen;
  logic [ADDR_W-1:0]   mcif2noc_axi_ar_araddr;
  logic                noc2mcif_axi_r_rvalid;
  logic                noc2mcif_axi_r_rready;
  logic [7:0]          noc2mcif_axi_r_rid;
  logic                noc2mcif_axi_r_rlast;
  logic [DATA_W-1:0]   noc2mcif_axi_r_rdata;
  logic                mcif2noc_axi_aw_awvalid;
  logic                mcif2noc_axi_aw_awready;
  logic [7:0]          mcif2noc_axi_aw_awid;
  logic [3:0]          mcif2noc_axi_aw_awlen;
  logic [ADDR_W-1:0]   mcif2noc_axi_aw_awaddr;
  logic                mcif2noc_axi_w_wvalid;
  logic                mcif2noc_axi_w_wready;
  logic [DATA_W-1:0]   mcif2noc_axi_w_wdata;
  logic [DATA_W/8-1:0] mcif2noc_axi_w_wstrb;
  logic                mcif2noc_axi_w_wlast;
  logic                noc2mcif_axi_b_bvalid;
  logic                noc2mcif_axi_b_bready;
  logic [7:0]          noc2mcif_axi_b_bid;

  modport master (
    output mcif2noc_axi_ar_arvalid, mcif2noc_axi_ar_arid, mcif2noc_axi_ar_arlen, mcif2noc_axi_ar_araddr,
    input  mcif2noc_axi_ar_arready,
    input  noc2mcif_axi_r_rvalid, noc2mcif_axi_r_rid, noc2mcif_axi_r_rlast, noc2mcif_axi_r_rdata,
    output noc2mcif_axi_r_rready,
    output mcif2noc_axi_aw_awvalid, mcif2noc_axi_aw_awid, mcif2noc_axi_aw_awlen, mcif2noc_axi_aw_awaddr,
    input  mcif2noc_axi_aw_awready,
    output mcif2noc_axi_w_wvalid, mcif2noc_axi_w_wdata, mcif2noc_axi_w_wstrb, mcif2noc_axi_w_wlast,
    input  mcif2noc_axi_w_wready,
    input  noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
    output noc2mcif_axi_b_bready
  );

  modport slave (
    input  mcif2noc_axi_ar_arvalid, mcif2noc_axi_ar_arid, mcif2noc_axi_ar_arlen, mcif2noc_axi_ar_araddr,
    output mcif2noc_axi_ar_arready,
    output noc2mcif_axi_r_rvalid, noc2mcif_axi_r_rid, noc2mcif_axi_r_rlast, noc2mcif_axi_r_rdata,
    input  noc2mcif_axi_r_rready,
    input  mcif2noc_axi_aw_awvalid, mcif2noc_axi_aw_awid, mcif2noc_axi_aw_awlen, mcif2noc_axi_aw_awaddr,
    output mcif2noc_axi_aw_awready,
    input  mcif2noc_axi_w_wvalid, mcif2noc_axi_w_wdata, mcif2noc_axi_w_wstrb, mcif2noc_axi_w_wlast,
    output mcif2noc_axi_w_wready,
    output noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
    input  noc2mcif_axi_b_bready
  );
endinterface

// File: rtl/nv_nvdla_nocif_axi_rsp.sv
// Flop-array AXI slave standing in for DRAM behind NOCIF: one read and one
// write burst in flight, independent engines, incrementing word index with wrap.
module nv_nvdla_nocif_axi_rsp #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  nv_nvdla_nocif_axi_rsp_if.slave axi,
  output logic proto_err
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.mcif2noc_axi_ar_araddr, axi.mcif2noc_axi_aw_awaddr};

  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
  assign ar_idx = axi.mcif2noc_axi_ar_araddr[OFF +: DEPTH_LOG2];
  assign aw_idx = axi.mcif2noc_axi_aw_awaddr[OFF +: DEPTH_LOG2];

  // ---------------- read engine ----------------
  logic [0:0]            r_state;
  logic [7:0]            r_id;
  logic [3:0]            r_len, r_beat;
  logic [DEPTH_LOG2-1:0] r_idx, r_idx_nxt;
  logic [DATA_W-1:0]     r_data;
  logic                  r_last;

  assign r_idx_nxt = r_idx + IDX_ONE;
  assign r_last    = (r_beat == r_len);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (axi.mcif2noc_axi_ar_arvalid) begin
          r_id    <= axi.mcif2noc_axi_ar_arid;
          r_len   <= axi.mcif2noc_axi_ar_arlen;
          r_beat  <= '0;
          r_idx   <= ar_idx;
          r_data  <= mem[ar_idx];
          r_state <= R_BURST;
        end
        default: if (axi.noc2mcif_axi_r_rready) begin
          // mem reads see pre-write content on a same-cycle collision
          r_beat <= r_beat + 4'd1;
          r_idx  <= r_idx_nxt;
          r_data <= mem[r_idx_nxt];
          if (r_last) r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign axi.mcif2noc_axi_ar_arready = (r_state == R_IDLE);
  assign axi.noc2mcif_axi_r_rvalid   = (r_state == R_BURST);
  assign axi.noc2mcif_axi_r_rid      = r_id;
  assign axi.noc2mcif_axi_r_rlast    = (r_state == R_BURST) && r_last;
  assign axi.noc2mcif_axi_r_rdata    = r_data;

  // ---------------- write engine ----------------
  logic [1:0]            w_state;
  logic [7:0]            w_id;
  logic [3:0]            w_len, w_beat;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_hs, w_last;

  assign w_hs   = axi.mcif2noc_axi_w_wvalid && (w_state == W_DATA);
  assign w_last = (w_beat == w_len);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_idx     <= '0;
      proto_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (axi.mcif2noc_axi_aw_awvalid) begin
          w_id    <= axi.mcif2noc_axi_aw_awid;
          w_len   <= axi.mcif2noc_axi_aw_awlen;
          w_beat  <= '0;
          w_idx   <= aw_idx;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_beat <= w_beat + 4'd1;
          w_idx  <= w_idx + IDX_ONE;
          // awlen decides the burst end; a disagreeing wlast only flags
          if (axi.mcif2noc_axi_w_wlast != w_last) proto_err <= 1'b1;
          if (w_last) w_state <= W_RESP;
        end
        W_RESP: if (axi.noc2mcif_axi_b_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++)
        if (axi.mcif2noc_axi_w_wstrb[b]) mem[w_idx][8*b +: 8] <= axi.mcif2noc_axi_w_wdata[8*b +: 8];
    end
  end

  assign axi.mcif2noc_axi_aw_awready = (w_state == W_IDLE);
  assign axi.mcif2noc_axi_w_wready   = (w_state == W_DATA);
  assign axi.noc2mcif_axi_b_bvalid   = (w_state == W_RESP);
  assign axi.noc2mcif_axi_b_bid      = w_id;
endmodule

// File: tb/tb_nv_nvdla_nocif_axi_rsp.sv
// Directed bench for the AXI responder: reference memory model plus R/B scoreboards.
module tb_nv_nvdla_nocif_axi_rsp;
  logic clk = 1'b0;
  logic rstn;
  logic proto_err;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] model [256];
  logic [72:0] r_q [$];   // {rid, rlast, rdata}
  logic [7:0]  b_q [$];

  always #5 clk = ~clk;

  nv_nvdla_nocif_axi_rsp_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  nv_nvdla_nocif_axi_rsp #(.ADDR_W(64), .DATA_W(64), .DEPTH_LOG2(8)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .axi            (bus.slave),
    .proto_err      (proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [3:0] len, input logic [63:0] addr,
                           input logic [63:0] base, input logic [7:0] strb, input int wlast_beat,
                           input bit get_b);
    int n; bit hs; logic [7:0] idx; logic [63:0] d;
    b_q.push_back(id);
    bus.mcif2noc_axi_aw_awvalid = 1'b1;
    bus.mcif2noc_axi_aw_awid    = id;
    bus.mcif2noc_axi_aw_awlen   = len;
    bus.mcif2noc_axi_aw_awaddr  = addr;
    hs = 0; n = 0;
    while (!hs && n < 20) begin hs = bus.mcif2noc_axi_aw_awready; @(negedge clk); n++; end
    chk("aw_handshake", 64'(hs), 64'd1);
    bus.mcif2noc_axi_aw_awvalid = 1'b0;
    idx = addr[10:3];
    for (int i = 0; i <= int'(len); i++) begin
      d = base + 64'(i);
      bus.mcif2noc_axi_w_wvalid = 1'b1;
      bus.mcif2noc_axi_w_wdata  = d;
      bus.mcif2noc_axi_w_wstrb  = strb;
      bus.mcif2noc_axi_w_wlast  = (i == wlast_beat);
      hs = 0; n = 0;
      while (!hs && n < 20) begin hs = bus.mcif2noc_axi_w_wready; @(negedge clk); n++; end
      chk("w_handshake", 64'(hs), 64'd1);
      for (int b = 0; b < 8; b++) if (strb[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      idx++;
    end
    bus.mcif2noc_axi_w_wvalid = 1'b0;
    bus.mcif2noc_axi_w_wlast  = 1'b0;
    if (get_b) begin
      bus.noc2mcif_axi_b_bready = 1'b1;
      hs = 0; n = 0;
      while (!hs && n < 20) begin
        if (bus.noc2mcif_axi_b_bvalid) begin
          hs = 1;
          chk("bid", 64'(bus.noc2mcif_axi_b_bid), 64'(b_q.pop_front()));
          chk("b_latency", 64'(n), 64'd0);
        end
        @(negedge clk); n++;
      end
      chk("b_seen", 64'(hs), 64'd1);
      chk("b_single", 64'(bus.noc2mcif_axi_b_bvalid), 64'd0);
      bus.noc2mcif_axi_b_bready = 1'b0;
    end else begin
      chk("b_pending", 64'(bus.noc2mcif_axi_b_bvalid), 64'd1);
      chk("bid_pending", 64'(bus.noc2mcif_axi_b_bid), 64'(b_q.pop_front()));
    end
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [3:0] len, input logic [63:0] addr,
                          input bit toggle);
    int n, beats; bit hs, stalled; logic [7:0] idx; logic [72:0] e; logic [63:0] prev_d; logic prev_l;
    idx = addr[10:3];
    for (int i = 0; i <= int'(len); i++) begin
      r_q.push_back({id, (i == int'(len)), model[idx]});
      idx++;
    end
    bus.mcif2noc_axi_ar_arvalid = 1'b1;
    bus.mcif2noc_axi_ar_arid    = id;
    bus.mcif2noc_axi_ar_arlen   = len;
    bus.mcif2noc_axi_ar_araddr  = addr;
    hs = 0; n = 0;
    while (!hs && n < 20) begin hs = bus.mcif2noc_axi_ar_arready; @(negedge clk); n++; end
    chk("ar_handshake", 64'(hs), 64'd1);
    bus.mcif2noc_axi_ar_arvalid = 1'b0;
    chk("r_latency", 64'(bus.noc2mcif_axi_r_rvalid), 64'd1);
    beats = 0; n = 0; stalled = 0; prev_d = '0; prev_l = 1'b0;
    while (beats <= int'(len) && n < 100) begin
      if (stalled) begin
        chk("r_stable_data", bus.noc2mcif_axi_r_rdata, prev_d);
        chk("r_stable_last", 64'(bus.noc2mcif_axi_r_rlast), 64'(prev_l));
      end
      if (bus.noc2mcif_axi_r_rvalid) chk("ar_blocked", 64'(bus.mcif2noc_axi_ar_arready), 64'd0);
      bus.noc2mcif_axi_r_rready = toggle ? n[0] : 1'b1;
      if (bus.noc2mcif_axi_r_rvalid && bus.noc2mcif_axi_r_rready) begin
        e = r_q.pop_front();
        chk("rdata", bus.noc2mcif_axi_r_rdata, e[63:0]);
        chk("rlast", 64'(bus.noc2mcif_axi_r_rlast), 64'(e[64]));
        chk("rid", 64'(bus.noc2mcif_axi_r_rid), 64'(e[72:65]));
        beats++;
      end
      stalled = bus.noc2mcif_axi_r_rvalid && !bus.noc2mcif_axi_r_rready;
      prev_d  = bus.noc2mcif_axi_r_rdata;
      prev_l  = bus.noc2mcif_axi_r_rlast;
      @(negedge clk); n++;
    end
    bus.noc2mcif_axi_r_rready = 1'b0;
    chk("r_beats", 64'(beats), 64'(len) + 64'd1);
    chk("r_done", 64'(bus.noc2mcif_axi_r_rvalid), 64'd0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.mcif2noc_axi_ar_arvalid = 1'b0; bus.mcif2noc_axi_ar_arid = '0;
    bus.mcif2noc_axi_ar_arlen = '0;     bus.mcif2noc_axi_ar_araddr = '0;
    bus.noc2mcif_axi_r_rready = 1'b0;
    bus.mcif2noc_axi_aw_awvalid = 1'b0; bus.mcif2noc_axi_aw_awid = '0;
    bus.mcif2noc_axi_aw_awlen = '0;     bus.mcif2noc_axi_aw_awaddr = '0;
    bus.mcif2noc_axi_w_wvalid = 1'b0;   bus.mcif2noc_axi_w_wdata = '0;
    bus.mcif2noc_axi_w_wstrb = '0;      bus.mcif2noc_axi_w_wlast = 1'b0;
    bus.noc2mcif_axi_b_bready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(bus.mcif2noc_axi_ar_arready), 64'd1);
    chk("rst_awready", 64'(bus.mcif2noc_axi_aw_awready), 64'd1);
    chk("rst_rvalid",  64'(bus.noc2mcif_axi_r_rvalid), 64'd0);
    chk("rst_wready",  64'(bus.mcif2noc_axi_w_wready), 64'd0);
    chk("rst_bvalid",  64'(bus.noc2mcif_axi_b_bvalid), 64'd0);
    chk("rst_proto",   64'(proto_err), 64'd0);
    chk("rst_rid",     64'(bus.noc2mcif_axi_r_rid), 64'd0);
    chk("rst_bid",     64'(bus.noc2mcif_axi_b_bid), 64'd0);
    chk("rst_rdata",   bus.noc2mcif_axi_r_rdata, 64'd0);
    chk("rst_rlast",   64'(bus.noc2mcif_axi_r_rlast), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // basic burst write then read back
    axi_write(8'h12, 4'd3, 64'h100, 64'hA0, 8'hFF, 3, 1'b1);
    chk("proto_clean", 64'(proto_err), 64'd0);
    axi_read(8'h34, 4'd3, 64'h100, 1'b0);

    // partial strobe and zero-strobe beats
    axi_write(8'h01, 4'd0, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b1);
    axi_write(8'h02, 4'd0, 64'h300, 64'h0, 8'h0F, 0, 1'b1);
    chk("strobe_model", model[8'h60], 64'hFFFF_FFFF_0000_0000);
    axi_read(8'h03, 4'd0, 64'h300, 1'b0);
    axi_write(8'h04, 4'd0, 64'h300, 64'h1234, 8'h00, 0, 1'b1);
    axi_read(8'h05, 4'd0, 64'h300, 1'b0);

    // index wrap on both engines
    axi_write(8'h06, 4'd1, 64'h7F8, 64'hC0, 8'hFF, 1, 1'b1);
    chk("wrap_model", model[0], 64'hC1);
    axi_read(8'h07, 4'd0, 64'h0, 1'b0);
    axi_read(8'h08, 4'd1, 64'h7F8, 1'b0);

    // read backpressure on a long burst
    axi_write(8'h09, 4'd7, 64'h200, 64'hB0, 8'hFF, 7, 1'b1);
    axi_read(8'h56, 4'd7, 64'h200, 1'b1);

    // early wlast: sticky error, B held, then reset clears
    axi_write(8'h77, 4'd2, 64'h400, 64'hD0, 8'hFF, 1, 1'b0);
    chk("proto_set", 64'(proto_err), 64'd1);
    @(negedge clk);
    chk("proto_sticky", 64'(proto_err), 64'd1);
    chk("b_held", 64'(bus.noc2mcif_axi_b_bvalid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rst2_proto",   64'(proto_err), 64'd0);
    chk("rst2_bvalid",  64'(bus.noc2mcif_axi_b_bvalid), 64'd0);
    chk("rst2_awready", 64'(bus.mcif2noc_axi_aw_awready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // memory survives reset
    axi_read(8'h35, 4'd3, 64'h100, 1'b0);
    axi_read(8'h36, 4'd2, 64'h400, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
